fold_dec_pipe: RTL and testbench

//  Parametrised, pipelined successor to the IFU folding decoder.
//  - Scans the instruction-buffer window for foldable integer groups of the forms LV/OP/ST.
//  - Emits a registered fold descriptor: count, consumed length, local-var indices, ALU opcode.
//  - Sits between the ibuffer and the IU dispatch stage; has valid/ready flow control and flush.

---
 rtl/fold_dec_pipe.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_fold_dec_pipe.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fold_dec_pipe.sv
// fold_dec_pipe: two-stage folding decoder for the instruction-buffer window.
// Stage 1 classifies every byte and walks the window to find insns 0..3.
// Stage 2 matches LV/OP/ST fold patterns and registers the fold descriptor.
// Define IFU_FOLD4_EN to enable the 4-insn LV LV OP ST fold; otherwise the
// longest fold is 3 insns.
module fold_dec_pipe #(
    parameter int IBUF_BYTES = 7,
    parameter int IDX_W      = 8
) (
    input  logic                    clk,
    input  logic                    reset_l,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*IBUF_BYTES-1:0] ibuff,
    input  logic [IBUF_BYTES-1:0]   fetch_valid,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2:0]              fold_cnt,
    output logic [4:0]              fold_len,
    output logic                    rs1_used,
    output logic [IDX_W-1:0]        rs1_idx,
    output logic                    rs2_used,
    output logic [IDX_W-1:0]        rs2_idx,
    output logic                    rsd_used,
    output logic [IDX_W-1:0]        rsd_idx,
    output logic [7:0]              alu_op
);

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_LV   = 2'd1,
        CLS_OP   = 2'd2,
        CLS_ST   = 2'd3
    } cls_e;

    localparam int         AW     = $clog2(IBUF_BYTES);
    localparam logic [4:0] NBYTES = 5'(IBUF_BYTES);

    // Per-byte decode, as if an insn started at every position.
    logic [7:0]       byte_w   [IBUF_BYTES];
    cls_e             byte_cls [IBUF_BYTES];
    logic [1:0]       byte_len [IBUF_BYTES];
    logic [IDX_W-1:0] byte_idx [IBUF_BYTES];

    genvar gi;
    generate
        for (gi = 0; gi < IBUF_BYTES; gi = gi + 1) begin : g_byte
            logic [7:0]       cur_b;
            logic [7:0]       nxt_b;
            logic             nxt_v;
            logic [7:0]       diff_lv;
            logic [7:0]       diff_st;
            cls_e             cls_l;
            logic [1:0]       len_l;
            logic [IDX_W-1:0] idx_l;

            assign cur_b   = ibuff[8*gi +: 8];
            assign diff_lv = cur_b - 8'h1a;
            assign diff_st = cur_b - 8'h3b;

            // The last byte has no successor, so a 2-byte insn there never completes.
            if (gi + 1 < IBUF_BYTES) begin : g_nxt
                assign nxt_b = ibuff[8*(gi+1) +: 8];
                assign nxt_v = fetch_valid[gi+1];
            end else begin : g_last
                assign nxt_b = 8'h00;
                assign nxt_v = 1'b0;
            end

            // Classify the opcode; an insn missing any byte degrades to NONE.
            always_comb begin
                cls_l = CLS_NONE;
                len_l = 2'd1;
                idx_l = '0;
                case (cur_b)
                    8'h1a, 8'h1b, 8'h1c, 8'h1d: begin
                        cls_l = CLS_LV;
                        idx_l = IDX_W'(diff_lv);
                    end
                    8'h15: begin
                        cls_l = CLS_LV;
                        len_l = 2'd2;
                        idx_l = IDX_W'(nxt_b);
                    end
                    8'h3b, 8'h3c, 8'h3d, 8'h3e: begin
                        cls_l = CLS_ST;
                        idx_l = IDX_W'(diff_st);
                    end
                    8'h36: begin
                        cls_l = CLS_ST;
                        len_l = 2'd2;
                        idx_l = IDX_W'(nxt_b);
                    end
                    8'h60, 8'h64, 8'h7e, 8'h80, 8'h82: begin
                        cls_l = CLS_OP;
                    end
                    default: begin
                        cls_l = CLS_NONE;
                    end
                endcase
                if (!fetch_valid[gi] || (len_l == 2'd2 && !nxt_v)) begin
                    cls_l = CLS_NONE;
                end
            end

            assign byte_w[gi]   = cur_b;
            assign byte_cls[gi] = cls_l;
            assign byte_len[gi] = len_l;
            assign byte_idx[gi] = idx_l;
        end
    endgenerate

    // Insn-level view of the window: class, index, opcode and end offset of insns 0..3.
    cls_e             ins_cls_c [4];
    logic [IDX_W-1:0] ins_idx_c [4];
    logic [7:0]       ins_op_c  [4];
    logic [4:0]       ins_end_c [4];

    // Walk the window, accumulating each insn's start offset from the previous length.
    always_comb begin
        logic [4:0] pos;
        pos = 5'd0;
        for (int j = 0; j < 4; j++) begin
            ins_cls_c[j] = CLS_NONE;
            ins_idx_c[j] = '0;
            ins_op_c[j]  = 8'h00;
            if (pos < NBYTES) begin
                ins_cls_c[j] = byte_cls[pos[AW-1:0]];
                ins_idx_c[j] = byte_idx[pos[AW-1:0]];
                ins_op_c[j]  = byte_w[pos[AW-1:0]];
                pos          = pos + {3'b000, byte_len[pos[AW-1:0]]};
            end else begin
                pos = pos + 5'd1;
            end
            ins_end_c[j] = pos;
        end
    end

    // Flow control: stage 1 drains into stage 2 whenever the output slot frees up.
    logic s1_valid_q;
    logic out_valid_q;
    logic out_free;
    logic s1_adv;
    logic in_fire;

    assign out_free = !out_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && out_free;
    assign in_ready = reset_l && (flush || !s1_valid_q || s1_adv);
    assign in_fire  = in_valid && in_ready && !flush;

    cls_e             s1_cls_q [4];
    logic [IDX_W-1:0] s1_idx_q [4];
    logic [7:0]       s1_op_q  [4];
    logic [4:0]       s1_end_q [4];

    // Stage 1 register: capture the insn view of an accepted window.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            s1_valid_q <= 1'b0;
            for (int j = 0; j < 4; j++) begin
                s1_cls_q[j] <= CLS_NONE;
                s1_idx_q[j] <= '0;
                s1_op_q[j]  <= 8'h00;
                s1_end_q[j] <= 5'd0;
            end
        end else begin
            if (flush) begin
                s1_valid_q <= 1'b0;
            end else if (in_fire) begin
                s1_valid_q <= 1'b1;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end
            if (in_fire) begin
                for (int j = 0; j < 4; j++) begin
                    s1_cls_q[j] <= ins_cls_c[j];
                    s1_idx_q[j] <= ins_idx_c[j];
                    s1_op_q[j]  <= ins_op_c[j];
                    s1_end_q[j] <= ins_end_c[j];
                end
            end
        end
    end

    logic [2:0]       cnt_d;
    logic [4:0]       len_d;
    logic             rs1_used_d, rs2_used_d, rsd_used_d;
    logic [IDX_W-1:0] rs1_idx_d, rs2_idx_d, rsd_idx_d;
    logic [7:0]       alu_op_d;

    // Pattern match, longest fold first; unused fields stay zero.
    always_comb begin
        cnt_d      = 3'd0;
        len_d      = 5'd0;
        rs1_used_d = 1'b0;
        rs1_idx_d  = '0;
        rs2_used_d = 1'b0;
        rs2_idx_d  = '0;
        rsd_used_d = 1'b0;
        rsd_idx_d  = '0;
        alu_op_d   = 8'h00;
`ifdef IFU_FOLD4_EN
        if (s1_cls_q[0] == CLS_LV && s1_cls_q[1] == CLS_LV &&
            s1_cls_q[2] == CLS_OP && s1_cls_q[3] == CLS_ST) begin
            cnt_d      = 3'd4;
            len_d      = s1_end_q[3];
            rs1_used_d = 1'b1;
            rs1_idx_d  = s1_idx_q[0];
            rs2_used_d = 1'b1;
            rs2_idx_d  = s1_idx_q[1];
            rsd_used_d = 1'b1;
            rsd_idx_d  = s1_idx_q[3];
            alu_op_d   = s1_op_q[2];
        end else
`endif
        if (s1_cls_q[0] == CLS_LV && s1_cls_q[1] == CLS_LV && s1_cls_q[2] == CLS_OP) begin
            cnt_d      = 3'd3;
            len_d      = s1_end_q[2];
            rs1_used_d = 1'b1;
            rs1_idx_d  = s1_idx_q[0];
            rs2_used_d = 1'b1;
            rs2_idx_d  = s1_idx_q[1];
            alu_op_d   = s1_op_q[2];
        end else if (s1_cls_q[0] == CLS_LV && s1_cls_q[1] == CLS_OP && s1_cls_q[2] == CLS_ST) begin
            cnt_d      = 3'd3;
            len_d      = s1_end_q[2];
            rs2_used_d = 1'b1;
            rs2_idx_d  = s1_idx_q[0];
            rsd_used_d = 1'b1;
            rsd_idx_d  = s1_idx_q[2];
            alu_op_d   = s1_op_q[1];
        end else if (s1_cls_q[0] == CLS_LV && s1_cls_q[1] == CLS_OP) begin
            cnt_d      = 3'd2;
            len_d      = s1_end_q[1];
            rs2_used_d = 1'b1;
            rs2_idx_d  = s1_idx_q[0];
            alu_op_d   = s1_op_q[1];
        end else if (s1_cls_q[0] == CLS_OP && s1_cls_q[1] == CLS_ST) begin
            cnt_d      = 3'd2;
            len_d      = s1_end_q[1];
            rsd_used_d = 1'b1;
            rsd_idx_d  = s1_idx_q[1];
            alu_op_d   = s1_op_q[0];
        end
    end

    logic [2:0]       cnt_q;
    logic [4:0]       len_q;
    logic             rs1_used_q, rs2_used_q, rsd_used_q;
    logic [IDX_W-1:0] rs1_idx_q, rs2_idx_q, rsd_idx_q;
    logic [7:0]       alu_op_q;

    // Stage 2 register: the descriptor only changes when stage 1 advances, so it holds under stall.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            out_valid_q <= 1'b0;
            cnt_q       <= 3'd0;
            len_q       <= 5'd0;
            rs1_used_q  <= 1'b0;
            rs1_idx_q   <= '0;
            rs2_used_q  <= 1'b0;
            rs2_idx_q   <= '0;
            rsd_used_q  <= 1'b0;
            rsd_idx_q   <= '0;
            alu_op_q    <= 8'h00;
        end else begin
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (s1_adv) begin
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (s1_adv && !flush) begin
                cnt_q      <= cnt_d;
                len_q      <= len_d;
                rs1_used_q <= rs1_used_d;
                rs1_idx_q  <= rs1_idx_d;
                rs2_used_q <= rs2_used_d;
                rs2_idx_q  <= rs2_idx_d;
                rsd_used_q <= rsd_used_d;
                rsd_idx_q  <= rsd_idx_d;
                alu_op_q   <= alu_op_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign fold_cnt  = cnt_q;
    assign fold_len  = len_q;
    assign rs1_used  = rs1_used_q;
    assign rs1_idx   = rs1_idx_q;
    assign rs2_used  = rs2_used_q;
    assign rs2_idx   = rs2_idx_q;
    assign rsd_used  = rsd_used_q;
    assign rsd_idx   = rsd_idx_q;
    assign alu_op    = alu_op_q;

endmodule

// File: tb/tb_fold_dec_pipe.sv
// Testbench for fold_dec_pipe: vector table streamed through a scoreboard,
// plus hand-written latency, stall, flush and mid-stream reset sequences.
// Expectations for the 4-insn fold follow IFU_FOLD4_EN.
`timescale 1ns/1ps
module tb_fold_dec_pipe;

    localparam int NB = 7;
    localparam int IW = 8;
`ifdef IFU_FOLD4_EN
    localparam bit F4 = 1'b1;
`else
    localparam bit F4 = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] cnt;
        logic [4:0] len;
        logic       r1u;
        logic [7:0] r1;
        logic       r2u;
        logic [7:0] r2;
        logic       rdu;
        logic [7:0] rd;
        logic [7:0] op;
    } desc_t;

    typedef struct packed {
        logic [8*NB-1:0] win;
        logic [NB-1:0]   fv;
        desc_t           exp;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset_l = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [8*NB-1:0] ibuff = '0;
    logic [NB-1:0]   fetch_valid = '0;
    logic            in_ready, out_valid;
    logic [2:0]      fold_cnt;
    logic [4:0]      fold_len;
    logic            rs1_used, rs2_used, rsd_used;
    logic [IW-1:0]   rs1_idx, rs2_idx, rsd_idx;
    logic [7:0]      alu_op;

    fold_dec_pipe #(.IBUF_BYTES(NB), .IDX_W(IW)) dut (
        .clk(clk), .reset_l(reset_l), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ibuff(ibuff), .fetch_valid(fetch_valid),
        .out_valid(out_valid), .out_ready(out_ready),
        .fold_cnt(fold_cnt), .fold_len(fold_len),
        .rs1_used(rs1_used), .rs1_idx(rs1_idx),
        .rs2_used(rs2_used), .rs2_idx(rs2_idx),
        .rsd_used(rsd_used), .rsd_idx(rsd_idx),
        .alu_op(alu_op)
    );

    always #5 clk = ~clk;

    desc_t act;
    assign act = {fold_cnt, fold_len, rs1_used, rs1_idx, rs2_used, rs2_idx, rsd_used, rsd_idx, alu_op};

    int    checks = 0;
    int    errors = 0;
    int    ndesc  = 0;
    desc_t cur_exp;
    desc_t sb_q[$];
    desc_t sb_e;
    vec_t  vecs[$];

    function automatic logic [8*NB-1:0] win(input logic [7:0] b0, b1, b2, b3, b4, b5, b6);
        return {b6, b5, b4, b3, b2, b1, b0};
    endfunction

    function automatic desc_t D(input logic [2:0] cnt, input logic [4:0] len,
                                input logic r1u, input logic [7:0] r1,
                                input logic r2u, input logic [7:0] r2,
                                input logic rdu, input logic [7:0] rd,
                                input logic [7:0] op);
        return {cnt, len, r1u, r1, r2u, r2, rdu, rd, op};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
        end
    endtask

    // Scoreboard: compare each handshaken descriptor, then record accepted windows.
    always @(negedge clk) begin
        if (!reset_l) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                ndesc++;
                $display("desc %0d cnt=%0d len=%0d rs1=%0b/%0h rs2=%0b/%0h rsd=%0b/%0h op=%02h",
                         ndesc, fold_cnt, fold_len, rs1_used, rs1_idx, rs2_used, rs2_idx,
                         rsd_used, rsd_idx, alu_op);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_desc got=%0h want=none", act);
                end else begin
                    sb_e = sb_q.pop_front();
                    chk("desc", act, sb_e);
                end
            end
            if (flush) sb_q.delete();
            else if (in_valid && in_ready) sb_q.push_back(cur_exp);
        end
    end

    task automatic send(input logic [8*NB-1:0] w, input logic [NB-1:0] fv, input desc_t e);
        int n;
        n = 0;
        ibuff = w; fetch_valid = fv; cur_exp = e; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got=in_ready0 want=in_ready1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // Accept in cycle N with an empty pipe; descriptor must show in N+2, not N+1.
    task automatic lat_check(input vec_t v);
        ibuff = v.win; fetch_valid = v.fv; cur_exp = v.exp; in_valid = 1'b1;
        @(negedge clk); chk("lat_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk); chk("lat_n1_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk); chk("lat_n2_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
    endtask

    // Fill both stages with out_ready low: window a in stage 2, window b in stage 1.
    task automatic fill2(input vec_t a, input vec_t b);
        out_ready = 1'b0;
        ibuff = a.win; fetch_valid = a.fv; cur_exp = a.exp; in_valid = 1'b1;
        @(negedge clk); chk("fill_acc1_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        ibuff = b.win; fetch_valid = b.fv; cur_exp = b.exp;
        @(negedge clk); chk("fill_acc2_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        desc_t snap;
        desc_t z;
        z = '0;
        vecs.push_back('{win(8'h1a,8'h1b,8'h60,8'h3c,8'h00,8'h00,8'h00), 7'h7f,
                         F4 ? D(4,4,1,8'h00,1,8'h01,1,8'h01,8'h60) : D(3,3,1,8'h00,1,8'h01,0,8'h00,8'h60)});
        vecs.push_back('{win(8'h15,8'h05,8'h1b,8'h64,8'h36,8'h07,8'h00), 7'h3f,
                         F4 ? D(4,6,1,8'h05,1,8'h01,1,8'h07,8'h64) : D(3,4,1,8'h05,1,8'h01,0,8'h00,8'h64)});
        vecs.push_back('{win(8'h1a,8'h1b,8'h60,8'h00,8'h00,8'h00,8'h00), 7'h03, z});
        vecs.push_back('{win(8'h1c,8'h7e,8'h3e,8'h00,8'h00,8'h00,8'h00), 7'h07,
                         D(3,3,0,8'h00,1,8'h02,1,8'h03,8'h7e)});
        vecs.push_back('{win(8'h80,8'h3b,8'h00,8'h00,8'h00,8'h00,8'h00), 7'h03,
                         D(2,2,0,8'h00,0,8'h00,1,8'h00,8'h80)});
        vecs.push_back('{win(8'h1d,8'h82,8'h00,8'h00,8'h00,8'h00,8'h00), 7'h7f,
                         D(2,2,0,8'h00,1,8'h03,0,8'h00,8'h82)});
        vecs.push_back('{win(8'h00,8'h1a,8'h60,8'h3b,8'h00,8'h00,8'h00), 7'h7f, z});
        vecs.push_back('{win(8'h1a,8'h1a,8'h00,8'h00,8'h00,8'h00,8'h00), 7'h7f, z});
        vecs.push_back('{win(8'h60,8'h36,8'h09,8'h00,8'h00,8'h00,8'h00), 7'h03, z});
        vecs.push_back('{win(8'h60,8'h36,8'h09,8'h00,8'h00,8'h00,8'h00), 7'h07,
                         D(2,3,0,8'h00,0,8'h00,1,8'h09,8'h60)});
        vecs.push_back('{win(8'h15,8'h01,8'h1b,8'h64,8'h36,8'h07,8'h00), 7'h1f,
                         D(3,4,1,8'h01,1,8'h01,0,8'h00,8'h64)});
        vecs.push_back('{win(8'h15,8'h01,8'h15,8'h02,8'h64,8'h36,8'h07), 7'h7f,
                         F4 ? D(4,7,1,8'h01,1,8'h02,1,8'h07,8'h64) : D(3,5,1,8'h01,1,8'h02,0,8'h00,8'h64)});
        vecs.push_back('{win(8'h1a,8'h60,8'h3b,8'h00,8'h00,8'h00,8'h00), 7'h7f,
                         D(3,3,0,8'h00,1,8'h00,1,8'h00,8'h60)});
        vecs.push_back('{win(8'h7e,8'h3d,8'h00,8'h00,8'h00,8'h00,8'h00), 7'h03,
                         D(2,2,0,8'h00,0,8'h00,1,8'h02,8'h7e)});
        vecs.push_back('{win(8'h1d,8'h1c,8'h80,8'h3e,8'h00,8'h00,8'h00), 7'h0f,
                         F4 ? D(4,4,1,8'h03,1,8'h02,1,8'h03,8'h80) : D(3,3,1,8'h03,1,8'h02,0,8'h00,8'h80)});

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_desc", act, z);
        @(negedge clk); reset_l = 1'b1;
        #1 chk("rel_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Table, streamed back to back.
        foreach (vecs[i]) send(vecs[i].win, vecs[i].fv, vecs[i].exp);
        drain();

        // Latency on an empty pipe.
        lat_check(vecs[1]);
        drain();

        // Stall: descriptor 1 held for 3 cycles, in_ready low after two accepts.
        fill2(vecs[0], vecs[3]);
        ibuff = vecs[4].win; fetch_valid = vecs[4].fv; cur_exp = vecs[4].exp;
        @(negedge clk);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_desc1", act, vecs[0].exp);
        snap = act;
        repeat (2) begin
            @(negedge clk);
            chk("stall_hold_desc", act, snap);
            chk("stall_hold_valid", 64'(out_valid), 64'd1);
            chk("stall_hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1; out_ready = 1'b1;
        @(negedge clk); chk("stall_release_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1; in_valid = 1'b0;
        drain();

        // Flush with both stages full and a window offered in the same cycle.
        fill2(vecs[3], vecs[5]);
        ibuff = vecs[9].win; fetch_valid = vecs[9].fv; cur_exp = vecs[9].exp; flush = 1'b1;
        @(negedge clk); chk("flush_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); chk("flush_out_valid", 64'(out_valid), 64'd0);
        repeat (3) begin
            @(negedge clk); chk("flush_no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        send(vecs[12].win, vecs[12].fv, vecs[12].exp);
        drain();

        // Asynchronous reset mid-stream.
        fill2(vecs[0], vecs[1]);
        in_valid = 1'b0;
        #2 reset_l = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_desc", act, z);
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("arst_hold_valid", 64'(out_valid), 64'd0);
        @(negedge clk); reset_l = 1'b1;
        #1 chk("arst_rel_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1; out_ready = 1'b1;
        chk("arst_no_partial", 64'(out_valid), 64'd0);
        lat_check(vecs[3]);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
